// File: rtl/axis_upsizer.sv
// Stream width up-converter: packs RATIO narrow beats into one wide word with
// a contiguous per-lane keep mask; a last beat closes the word early.
module axis_upsizer #(
    parameter int DWIDTH = 8,
    parameter int RATIO  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DWIDTH-1:0]         s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DWIDTH*RATIO-1:0]   m_data,
    output logic [RATIO-1:0]          m_keep,
    output logic                      m_last
);

    localparam int CW = $clog2(RATIO);
    localparam int WW = DWIDTH * RATIO;
    localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

    logic [CW-1:0]    cnt_r;
    logic [WW-1:0]    acc_data_r;
    logic [RATIO-1:0] acc_keep_r;
    logic             m_valid_r;
    logic [WW-1:0]    m_data_r;
    logic [RATIO-1:0] m_keep_r;
    logic             m_last_r;

    logic             ready_s;
    logic             accept_s;
    logic             complete_s;
    logic [WW-1:0]    merged_data_s;
    logic [RATIO-1:0] merged_keep_s;

    // Handshake decode and accumulator merged with the incoming beat
    always_comb begin
        ready_s       = ~m_valid_r | m_ready;
        accept_s      = s_valid & ready_s;
        complete_s    = accept_s & ((cnt_r == LAST_LANE) | s_last);
        merged_data_s = acc_data_r;
        merged_keep_s = acc_keep_r;
        merged_data_s[cnt_r*DWIDTH +: DWIDTH] = s_data;
        merged_keep_s[cnt_r] = 1'b1;
    end

    // Lane accumulator: fills lane by lane, cleared when a word is handed off
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            acc_data_r <= '0;
            acc_keep_r <= '0;
        end else if (complete_s) begin
            cnt_r      <= '0;
            acc_data_r <= '0;
            acc_keep_r <= '0;
        end else if (accept_s) begin
            cnt_r      <= cnt_r + CW'(1);
            acc_data_r <= merged_data_s;
            acc_keep_r <= merged_keep_s;
        end else begin
            cnt_r      <= cnt_r;
            acc_data_r <= acc_data_r;
            acc_keep_r <= acc_keep_r;
        end
    end

    // Output word register; a new word may replace one transferring this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_keep_r  <= '0;
            m_last_r  <= 1'b0;
        end else if (complete_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= merged_data_s;
            m_keep_r  <= merged_keep_s;
            m_last_r  <= s_last;
        end else if (m_valid_r & m_ready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    assign s_ready = ready_s;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_keep  = m_keep_r;
    assign m_last  = m_last_r;

endmodule

// File: tb/tb_axis_upsizer.sv
// Self-checking bench for axis_upsizer: directed vector table, hand-written
// stall/reset sequences and a randomized run against a queue-based model.
module tb_axis_upsizer;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int WW = DW * R;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready, m_last;
    logic [WW-1:0] m_data;
    logic [R-1:0]  m_keep;

    int n_tests = 0;
    int n_fail  = 0;

    axis_upsizer #(.DWIDTH(DW), .RATIO(R)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_keep(m_keep), .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          sl;
        logic          mr;
        logic          er;
        logic          ev;
        logic [WW-1:0] ed;
        logic [R-1:0]  ek;
        logic          el;
    } vec_t;

    typedef struct {
        logic [WW-1:0] d;
        logic [R-1:0]  k;
        logic          l;
    } word_t;

    vec_t  vt[$];
    word_t outq[$];
    logic [DW-1:0] pend[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = r;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic add(input logic sv, input logic [DW-1:0] sd, input logic sl, input logic mr,
                       input logic er, input logic ev, input logic [WW-1:0] ed,
                       input logic [R-1:0] ek, input logic el);
        vec_t v;
        v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr; v.er = er;
        v.ev = ev; v.ed = ed; v.ek = ek; v.el = el;
        vt.push_back(v);
    endtask

    initial begin
        logic          rv, rr, rl, exp_ready, ok;
        logic [DW-1:0] rd;
        word_t         w;

        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Full word, partial words with one stall, back-to-back stream
        add(1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        add(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        add(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        add(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b1);
        add(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        add(1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 1'b1);
        add(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000BBAA, 4'h3, 1'b1);
        add(1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 32'h000000CC, 4'h1, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            if (i == 4)
                add(1'b1, 8'(i), 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0);
            else if (i == 8)
                add(1'b1, 8'(i), 1'b1, 1'b1, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b1);
            else
                add(1'b1, 8'(i), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        end
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);

        // Reset state
        do_reset();
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_m_keep", 32'(m_keep), 32'h0);
        chk("rst_m_last", 32'(m_last), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h1);
        tick();

        foreach (vt[i]) begin
            drive(vt[i].sv, vt[i].sd, vt[i].sl, vt[i].mr);
            #1;
            chk($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(vt[i].er));
            tick();
            chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(vt[i].ev));
            if (vt[i].ev) begin
                chk($sformatf("tbl%0d_m_data", i), m_data, vt[i].ed);
                chk($sformatf("tbl%0d_m_keep", i), 32'(m_keep), 32'(vt[i].ek));
                chk($sformatf("tbl%0d_m_last", i), 32'(m_last), 32'(vt[i].el));
            end
        end

        // Backpressure: word held 5 cycles, pending beat lands in lane 0 on release
        do_reset();
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(8'h11 * i), i == 4, 1'b1);
            tick();
        end
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_s_ready", 32'(s_ready), 32'h0);
            tick();
            chk("bp_m_valid", 32'(m_valid), 32'h1);
            chk("bp_m_data", m_data, 32'h44332211);
            chk("bp_m_keep", 32'(m_keep), 32'hF);
            chk("bp_m_last", 32'(m_last), 32'h1);
        end
        drive(1'b1, 8'h55, 1'b0, 1'b1);
        #1;
        chk("bp_release_ready", 32'(s_ready), 32'h1);
        tick();
        chk("bp_release_valid", 32'(m_valid), 32'h0);
        drive(1'b1, 8'h66, 1'b1, 1'b1);
        tick();
        chk("bp_lane0_data", m_data, 32'h00006655);
        chk("bp_lane0_keep", 32'(m_keep), 32'h3);

        // Reset mid-packet discards accumulated lanes
        drive(1'b1, 8'h11, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'h22, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_during_valid", 32'(m_valid), 32'h0);
        tick();
        rst = 1'b0;
        chk("mid_rst_after_valid", 32'(m_valid), 32'h0);
        chk("mid_rst_after_ready", 32'(s_ready), 32'h1);
        drive(1'b1, 8'h99, 1'b1, 1'b1);
        tick();
        chk("mid_rst_word_valid", 32'(m_valid), 32'h1);
        chk("mid_rst_word_data", m_data, 32'h00000099);
        chk("mid_rst_word_keep", 32'(m_keep), 32'h1);
        chk("mid_rst_word_last", 32'(m_last), 32'h1);

        // Randomized run against the packing model
        do_reset();
        outq.delete();
        pend.delete();
        for (int c = 0; c < 10000; c++) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 9) < 7);
            rl = ($urandom_range(0, 4) == 0);
            rd = 8'($urandom);
            drive(rv, rd, rl, rr);
            #1;
            exp_ready = (outq.size() == 0) || rr;
            ok = (s_ready === exp_ready) && (m_valid === (outq.size() != 0));
            if (outq.size() != 0)
                ok = ok && (m_data === outq[0].d) && (m_keep === outq[0].k) && (m_last === outq[0].l);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand cycle %0d: got rdy=%0b v=%0b d=0x%0h k=0x%0h l=%0b expected rdy=%0b v=%0b d=0x%0h k=0x%0h l=%0b",
                         c, s_ready, m_valid, m_data, m_keep, m_last, exp_ready, outq.size() != 0,
                         outq.size() != 0 ? outq[0].d : 32'h0, outq.size() != 0 ? outq[0].k : 4'h0,
                         outq.size() != 0 ? outq[0].l : 1'b0);
            end
            if (outq.size() != 0 && rr)
                void'(outq.pop_front());
            if (rv && exp_ready) begin
                pend.push_back(rd);
                if (pend.size() == R || rl) begin
                    w.d = '0;
                    foreach (pend[k])
                        w.d = w.d | (WW'(pend[k]) << (DW * k));
                    w.k = R'((1 << pend.size()) - 1);
                    w.l = rl;
                    outq.push_back(w);
                    pend.delete();
                end
            end
            tick();
        end

        drive(1'b0, 8'h00, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
